// File: rtl/io_dma_port.sv
// io_dma_port: DMA-capable I/O peripheral buffering data between a device port and the
// DMA bus through a DEPTH-entry FIFO, requesting service in BURST_LEN-beat bursts.
module io_dma_port #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ENABLE,
  input  logic                       DIR,
  output logic                       DREQ,
  input  logic                       DACK,
  input  logic                       CB_IOR,
  input  logic                       CB_IOW,
  input  logic [DATA_W-1:0]          DB_IN,
  output logic [DATA_W-1:0]          DB_OUT,
  output logic                       DB_OE,
  input  logic                       DEV_WR,
  input  logic [DATA_W-1:0]          DEV_WDATA,
  input  logic                       DEV_RD,
  output logic [DATA_W-1:0]          DEV_RDATA,
  output logic [$clog2(DEPTH+1)-1:0] LEVEL,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       TC,
  output logic                       ERR,
  input  logic                       ERR_CLR
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] BURST_L   = LW'(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER
  } state_e;

  state_e            state_q, state_d;
  logic              dir_q;
  logic [BW-1:0]     beats_q, beats_d;
  logic              tc_q, tc_d;
  logic              err_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_idle, in_xfer, dir_change, flush;
  logic              rd_beat, wr_beat, beat;
  logic              push_req, pop_req, push_ok, pop_ok;
  logic [DATA_W-1:0] push_data;
  logic              req_cond;
  logic              bus_err, dir_err, fifo_err, any_err;

  assign in_idle    = (state_q == S_IDLE);
  assign in_xfer    = (state_q == S_XFER);
  assign dir_change = (DIR != dir_q);
  // A direction change only takes effect from IDLE, where it empties the FIFO.
  assign flush      = in_idle & dir_change;

  assign rd_beat = DACK & in_xfer & CB_IOR & ~CB_IOW & ~dir_q;
  assign wr_beat = DACK & in_xfer & CB_IOW & ~CB_IOR &  dir_q;
  assign beat    = rd_beat | wr_beat;

  // Each direction has exactly one producer and one consumer of FIFO entries.
  assign push_req  = ~flush & (dir_q ? wr_beat : DEV_WR);
  assign pop_req   = ~flush & (dir_q ? DEV_RD  : rd_beat);
  assign push_data = dir_q ? DB_IN : DEV_WDATA;
  assign pop_ok    = pop_req & (level_q != '0);
  assign push_ok   = push_req & ((level_q != DEPTH_L) | pop_ok);

  assign req_cond = dir_q ? ((DEPTH_L - level_q) >= BURST_L) : (level_q >= BURST_L);

  // Any strobe under DACK that does not form a valid beat is a protocol error.
  assign bus_err  = DACK & (CB_IOR | CB_IOW) & ~beat;
  assign dir_err  = dir_change & ~in_idle;
  assign fifo_err = (push_req & ~push_ok) | (pop_req & ~pop_ok);
  assign any_err  = bus_err | dir_err | fifo_err;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    beats_d = beats_q;
    tc_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!dir_change && ENABLE && req_cond) state_d = S_REQ;
      end
      S_REQ: begin
        if (DACK) state_d = S_XFER;
      end
      S_XFER: begin
        if (!DACK) begin
          state_d = S_REQ;
        end else if (beat) begin
          if (beats_q == LAST_BEAT) begin
            tc_d    = 1'b1;
            beats_d = '0;
            state_d = S_IDLE;
          end else begin
            beats_d = beats_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RST) begin
      state_q  <= S_IDLE;
      dir_q    <= DIR;
      beats_q  <= '0;
      tc_q     <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      tc_q    <= tc_d;
      if (any_err) begin
        err_q <= 1'b1;
      end else if (ERR_CLR) begin
        err_q <= 1'b0;
      end
      if (flush) begin
        dir_q    <= DIR;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
        level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
      end
    end
  end

  // NOTE: storage is not reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign DB_OUT    = mem[rd_ptr_q];
  assign DEV_RDATA = mem[rd_ptr_q];
  assign DB_OE     = DACK & CB_IOR & ~dir_q;
  assign DREQ      = (state_q == S_REQ) | (state_q == S_XFER);
  assign LEVEL     = level_q;
  assign FULL      = (level_q == DEPTH_L);
  assign EMPTY     = (level_q == '0);
  assign TC        = tc_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_io_dma_port.sv
// Testbench for io_dma_port: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based behavioural model of the peripheral.
module tb_io_dma_port;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int BURST_LEN = 4;
  localparam int LW        = $clog2(DEPTH + 1);

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              ENABLE = 1'b0, DIR = 1'b0, DACK = 1'b0;
  logic              CB_IOR = 1'b0, CB_IOW = 1'b0;
  logic              DEV_WR = 1'b0, DEV_RD = 1'b0, ERR_CLR = 1'b0;
  logic [DATA_W-1:0] DB_IN = '0, DEV_WDATA = '0;
  logic [DATA_W-1:0] DB_OUT, DEV_RDATA;
  logic [LW-1:0]     LEVEL;
  logic              DREQ, DB_OE, FULL, EMPTY, TC, ERR;

  io_dma_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .DIR(DIR), .DREQ(DREQ), .DACK(DACK),
    .CB_IOR(CB_IOR), .CB_IOW(CB_IOW), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
    .DEV_WR(DEV_WR), .DEV_WDATA(DEV_WDATA), .DEV_RD(DEV_RD), .DEV_RDATA(DEV_RDATA),
    .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY), .TC(TC), .ERR(ERR), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a data queue plus "requesting" and "acknowledged on the previous
  // clock" flags; beats only count once DACK has been seen on an earlier clock of the request.
  logic [DATA_W-1:0] mq[$];
  bit m_dir, m_dreq, m_ack_prev, m_tc, m_err;
  int m_beats;

  always @(posedge CLK) begin : model
    bit xfer, rd_b, wr_b, err, push, pop;
    int lvl0;
    logic [DATA_W-1:0] pd;
    if (RST) begin
      mq.delete();
      m_dir = DIR; m_dreq = 0; m_ack_prev = 0; m_beats = 0; m_tc = 0; m_err = 0;
    end else begin
      lvl0 = mq.size();
      xfer = m_dreq && m_ack_prev;
      rd_b = DACK && xfer && CB_IOR && !CB_IOW && !m_dir;
      wr_b = DACK && xfer && CB_IOW && !CB_IOR && m_dir;
      err  = DACK && (CB_IOR || CB_IOW) && !(rd_b || wr_b);
      if (DIR != m_dir && m_dreq) err = 1;
      m_tc = 0;
      if (!m_dreq && DIR != m_dir) begin
        mq.delete();
        m_dir = DIR;
      end else begin
        push = m_dir ? wr_b : DEV_WR;
        pop  = m_dir ? DEV_RD : rd_b;
        pd   = m_dir ? DB_IN : DEV_WDATA;
        if (pop) begin
          if (mq.size() == 0) err = 1;
          else void'(mq.pop_front());
        end
        if (push) begin
          if (mq.size() == DEPTH) err = 1;
          else mq.push_back(pd);
        end
        if (!m_dreq) begin
          if (ENABLE && (m_dir ? (DEPTH - lvl0 >= BURST_LEN) : (lvl0 >= BURST_LEN))) m_dreq = 1;
          m_ack_prev = 0;
        end else begin
          if (rd_b || wr_b) begin
            m_beats++;
            if (m_beats == BURST_LEN) begin
              m_tc = 1; m_beats = 0; m_dreq = 0;
            end
          end
          m_ack_prev = m_dreq && DACK;
        end
      end
      if (err) m_err = 1;
      else if (ERR_CLR) m_err = 0;
    end
  end

  always @(negedge CLK) begin
    #2;
    if (cmp_on) begin
      check("DREQ", DREQ, m_dreq);
      check("TC", TC, m_tc);
      check("ERR", ERR, m_err);
      check("LEVEL", LEVEL, mq.size());
      check("FULL", FULL, mq.size() == DEPTH);
      check("EMPTY", EMPTY, mq.size() == 0);
      check("DB_OE", DB_OE, DACK && CB_IOR && !m_dir);
      if (mq.size() != 0) begin
        check("DB_OUT", DB_OUT, mq[0]);
        check("DEV_RDATA", DEV_RDATA, mq[0]);
      end
    end
  end

  initial begin
    int r;
    repeat (2) @(negedge CLK);
    cmp_on = 1'b1;
    #3;
    check("rst_dreq", DREQ, 0);
    check("rst_level", LEVEL, 0);
    check("rst_empty", EMPTY, 1);
    check("rst_full", FULL, 0);
    check("rst_err", ERR, 0);
    @(negedge CLK); RST = 0; ENABLE = 1;

    // 1: device->memory burst
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); DEV_WR = 1; DEV_WDATA = 8'hA1 + 8'(i);
    end
    @(negedge CLK); DEV_WR = 0; #3;
    check("t1_level4", LEVEL, 4);
    check("t1_dreq_lag", DREQ, 0);
    @(negedge CLK); DACK = 1; #3;
    check("t1_dreq", DREQ, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); CB_IOR = 1; #3;
      check("t1_db_out", DB_OUT, 8'hA1 + i);
      check("t1_db_oe", DB_OE, 1);
    end
    @(negedge CLK); CB_IOR = 0; DACK = 0; #3;
    check("t1_tc", TC, 1);
    check("t1_dreq_low", DREQ, 0);
    check("t1_level0", LEVEL, 0);
    @(negedge CLK); #3;
    check("t1_tc_once", TC, 0);
    check("t1_err", ERR, 0);

    // 2: memory->device burst with a DACK gap
    @(negedge CLK); DIR = 1;
    @(negedge CLK); #3;
    check("t2_flush_level", LEVEL, 0);
    check("t2_dreq_flush", DREQ, 0);
    @(negedge CLK); DACK = 1; ENABLE = 0; #3;
    check("t2_dreq_empty", DREQ, 1);
    @(negedge CLK); CB_IOW = 1; DB_IN = 8'h10;
    @(negedge CLK); DB_IN = 8'h11;
    @(negedge CLK); CB_IOW = 0; DACK = 0;
    @(negedge CLK); DACK = 1; #3;
    check("t2_dreq_held", DREQ, 1);
    check("t2_level2", LEVEL, 2);
    @(negedge CLK); CB_IOW = 1; DB_IN = 8'h12;
    @(negedge CLK); DB_IN = 8'h13;
    @(negedge CLK); CB_IOW = 0; DACK = 0; #3;
    check("t2_tc", TC, 1);
    check("t2_dreq_low", DREQ, 0);
    check("t2_level4", LEVEL, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); DEV_RD = 1; #3;
      check("t2_dev_rdata", DEV_RDATA, 8'h10 + i);
    end
    @(negedge CLK); DEV_RD = 0; #3;
    check("t2_level0", LEVEL, 0);
    check("t2_err", ERR, 0);

    // 3: overflow sets the sticky error, ERR_CLR clears it
    @(negedge CLK); DIR = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK); DEV_WR = 1; DEV_WDATA = 8'h20 + 8'(i);
      if (i == 16) begin
        #3;
        check("t3_full", FULL, 1);
        check("t3_level16", LEVEL, 16);
      end
    end
    @(negedge CLK); DEV_WR = 0; #3;
    check("t3_err", ERR, 1);
    check("t3_level_kept", LEVEL, 16);
    check("t3_head", DB_OUT, 8'h20);
    @(negedge CLK); ERR_CLR = 1;
    @(negedge CLK); ERR_CLR = 0; #3;
    check("t3_err_clr", ERR, 0);

    // 4: reset two beats into a burst
    @(negedge CLK); ENABLE = 1;
    @(negedge CLK); DACK = 1; #3;
    check("t4_dreq", DREQ, 1);
    @(negedge CLK); CB_IOR = 1;
    @(negedge CLK);
    @(negedge CLK); CB_IOR = 0; DACK = 0; RST = 1; #3;
    check("t4_level_mid", LEVEL, 14);
    @(negedge CLK); RST = 0; #3;
    check("t4_dreq", DREQ, 0);
    check("t4_level", LEVEL, 0);
    check("t4_no_tc", TC, 0);
    @(negedge CLK); #3;
    check("t4_idle", DREQ, 0);
    check("t4_no_tc2", TC, 0);

    // 5: simultaneous push and bus pop, then both strobes at once
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); DEV_WR = 1; DEV_WDATA = 8'h50 + 8'(i);
    end
    @(negedge CLK); DEV_WR = 0; DACK = 1; #3;
    check("t5_dreq", DREQ, 1);
    check("t5_level5", LEVEL, 5);
    @(negedge CLK); DEV_WR = 1; DEV_WDATA = 8'h55; CB_IOR = 1; #3;
    check("t5_head50", DB_OUT, 8'h50);
    @(negedge CLK); DEV_WR = 0; CB_IOW = 1; #3;
    check("t5_level_same", LEVEL, 5);
    check("t5_head51", DB_OUT, 8'h51);
    @(negedge CLK); CB_IOW = 0; ERR_CLR = 1; #3;
    check("t5_err_both", ERR, 1);
    check("t5_no_pop", LEVEL, 5);
    @(negedge CLK); ERR_CLR = 0; #3;
    check("t5_err_clr", ERR, 0);
    check("t5_head52", DB_OUT, 8'h52);
    @(negedge CLK);
    @(negedge CLK); CB_IOR = 0; DACK = 0; #3;
    check("t5_tc", TC, 1);
    check("t5_level2", LEVEL, 2);
    check("t5_head54", DB_OUT, 8'h54);

    // 6: direction change in IDLE flushes, in XFER only flags an error
    @(negedge CLK); DEV_WR = 1; DEV_WDATA = 8'h60;
    @(negedge CLK); DEV_WR = 0; DIR = 1; #3;
    check("t6_level3", LEVEL, 3);
    @(negedge CLK); #3;
    check("t6_flush", LEVEL, 0);
    check("t6_dreq_flush", DREQ, 0);
    @(negedge CLK); DACK = 1; #3;
    check("t6_dreq", DREQ, 1);
    @(negedge CLK); CB_IOW = 1; DB_IN = 8'h70;
    @(negedge CLK); CB_IOW = 0; DIR = 0;
    @(negedge CLK); #3;
    check("t6_err_xfer", ERR, 1);
    check("t6_no_flush", LEVEL, 1);
    check("t6_dreq_kept", DREQ, 1);
    check("t6_data", DEV_RDATA, 8'h70);

    @(negedge CLK); RST = 1; DACK = 0; DIR = 0;
    @(negedge CLK); RST = 0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      RST = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 149) == 0) DIR = ~DIR;
      ENABLE = ($urandom_range(0, 7) != 0);
      DACK = DREQ ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 19);
      CB_IOR = 0; CB_IOW = 0;
      if (DACK) begin
        if (r < 13) begin
          if (DIR) CB_IOW = 1; else CB_IOR = 1;
        end else if (r == 13) begin
          CB_IOR = 1; CB_IOW = 1;
        end else if (r == 14) begin
          if (DIR) CB_IOR = 1; else CB_IOW = 1;
        end
      end
      DB_IN     = 8'($urandom);
      DEV_WDATA = 8'($urandom);
      DEV_WR    = !DIR ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      DEV_RD    =  DIR ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      ERR_CLR   = ($urandom_range(0, 5) == 0);
    end

    @(negedge CLK);
    RST = 0; DACK = 0; CB_IOR = 0; CB_IOW = 0; DEV_WR = 0; DEV_RD = 0; ERR_CLR = 0;
    repeat (2) @(negedge CLK);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
